// File: rtl/tcm_pkg.sv
// Shared types and helpers for the auto-loading TCM: loader state encoding,
// constant clog2 and byte-address to word-index mapping with range check.
package tcm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } ld_state_e;

    typedef struct packed {
        logic        ok;
        logic [63:0] idx;
    } tcm_map_t;

    function automatic int unsigned clog2(input longint unsigned v);
        int unsigned     r;
        longint unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r++;
        end
        return r;
    endfunction

    // Addresses below base wrap in the subtraction, hence the explicit >= test.
    function automatic tcm_map_t addr_map(input logic [63:0]     addr,
                                          input logic [63:0]     base,
                                          input logic [63:0]     depth,
                                          input int unsigned     shift);
        tcm_map_t    m;
        logic [63:0] off;
        off   = addr - base;
        m.idx = off >> shift;
        m.ok  = (addr >= base) && (m.idx < depth);
        return m;
    endfunction

endpackage

// File: rtl/tcm_sram_1w2r.sv
// DEPTH x DATA_W storage: one byte-enable write port, two registered read ports.
// TCM_WR_BYPASS_EN: a read colliding with a write returns the byte-merged new word.
module tcm_sram_1w2r
    import tcm_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8192,
    parameter int unsigned AW     = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_W/8-1:0]   wbe,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  ra_en,
    input  logic                  ra_zero,
    input  logic [AW-1:0]         ra_addr,
    output logic [DATA_W-1:0]     ra_data,
    input  logic                  rb_en,
    input  logic                  rb_zero,
    input  logic [AW-1:0]         rb_addr,
    output logic [DATA_W-1:0]     rb_data
);

    localparam int unsigned BYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ra_next;
    logic [DATA_W-1:0] rb_next;

`ifdef TCM_WR_BYPASS_EN
    function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [BYTES-1:0]  be);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int b = 0; b < int'(BYTES); b++) begin
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction
`endif

    always_comb begin
        ra_next = mem[ra_addr];
        rb_next = mem[rb_addr];
`ifdef TCM_WR_BYPASS_EN
        if (we && (waddr == ra_addr)) ra_next = byte_merge(mem[ra_addr], wdata, wbe);
        if (we && (waddr == rb_addr)) rb_next = byte_merge(mem[rb_addr], wdata, wbe);
`endif
    end

    // Contents are deliberately not reset so a reset does not wipe loaded code.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ra_data <= '0;
            rb_data <= '0;
        end else begin
            if (ra_en) ra_data <= ra_zero ? '0 : ra_next;
            if (rb_en) rb_data <= rb_zero ? '0 : rb_next;
        end
    end

endmodule

// File: rtl/tcm_autoload.sv
// Tightly-coupled memory with fetch and debug ports plus a boot loader that
// fills it from the system bus. Optional macro: TCM_WR_BYPASS_EN (in tcm_sram_1w2r).
//
// state | meaning
// IDLE  | loader inactive, fetch/debug ports open
// REQ   | presenting ld_req for word load_cnt
// WAIT  | request accepted, waiting for the bus response
module tcm_autoload
    import tcm_pkg::*;
#(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DEPTH      = 8192,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int unsigned       LOAD_WORDS = DEPTH,
    parameter logic [ADDR_W-1:0] LOAD_SRC   = BASE_ADDR
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          if_req,
    input  logic [ADDR_W-1:0]             if_addr,
    output logic                          if_ready,
    output logic                          if_rvalid,
    output logic [DATA_W-1:0]             if_rdata,
    input  logic                          dbg_req,
    input  logic                          dbg_we,
    input  logic [ADDR_W-1:0]             dbg_addr,
    input  logic [DATA_W/8-1:0]           dbg_be,
    input  logic [DATA_W-1:0]             dbg_wdata,
    output logic                          dbg_ready,
    output logic                          dbg_rvalid,
    output logic [DATA_W-1:0]             dbg_rdata,
    output logic                          ld_req_valid,
    input  logic                          ld_req_ready,
    output logic [ADDR_W-1:0]             ld_req_addr,
    input  logic                          ld_rsp_valid,
    input  logic [DATA_W-1:0]             ld_rsp_data,
    input  logic                          ld_rsp_err,
    input  logic                          reload,
    output logic                          busy,
    output logic                          load_err,
    output logic [clog2(DEPTH+1)-1:0]     load_cnt
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned SHIFT = clog2(BYTES);
    localparam int unsigned AW    = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int unsigned CW    = clog2(DEPTH + 1);

    ld_state_e         state;
    ld_state_e         state_d;
    logic [CW-1:0]     cnt_d;
    logic              err_d;
    logic              ld_we;

    tcm_map_t          if_map;
    tcm_map_t          dbg_map;
    logic              if_acc;
    logic              dbg_rd;
    logic              dbg_wr;

    logic              wr_en;
    logic [AW-1:0]     wr_idx;
    logic [BYTES-1:0]  wr_be;
    logic [DATA_W-1:0] wr_data;
    logic              unused_map;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= (LOAD_WORDS != 0) ? REQ : IDLE;
            load_cnt <= '0;
            load_err <= 1'b0;
        end else begin
            state    <= state_d;
            load_cnt <= cnt_d;
            load_err <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = load_cnt;
        err_d   = load_err;
        ld_we   = 1'b0;
        unique case (state)
            IDLE: begin
                if (reload && (LOAD_WORDS != 0)) begin
                    state_d = REQ;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            REQ: begin
                if (ld_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (ld_rsp_valid) begin
                    if (ld_rsp_err) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ld_we   = 1'b1;
                        cnt_d   = load_cnt + 1'b1;
                        state_d = (cnt_d == CW'(LOAD_WORDS)) ? IDLE : REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The reset state is REQ, so the request is masked while rst is held.
    assign busy         = (state != IDLE);
    assign ld_req_valid = (state == REQ) && !rst;
    assign ld_req_addr  = LOAD_SRC + (ADDR_W'(load_cnt) << SHIFT);

    assign if_ready  = !busy;
    assign dbg_ready = !busy;

    assign if_map  = addr_map(64'(if_addr),  64'(BASE_ADDR), 64'(DEPTH), SHIFT);
    assign dbg_map = addr_map(64'(dbg_addr), 64'(BASE_ADDR), 64'(DEPTH), SHIFT);
    assign unused_map = ^{if_map.idx[63:AW], dbg_map.idx[63:AW]};

    assign if_acc = if_req && !busy;
    assign dbg_rd = dbg_req && !dbg_we && !busy;
    assign dbg_wr = dbg_req && dbg_we && !busy && dbg_map.ok;

    // Loader and debug writes are mutually exclusive through busy.
    assign wr_en   = (ld_we && !rst) || dbg_wr;
    assign wr_idx  = ld_we ? load_cnt[AW-1:0] : dbg_map.idx[AW-1:0];
    assign wr_be   = ld_we ? {BYTES{1'b1}} : dbg_be;
    assign wr_data = ld_we ? ld_rsp_data : dbg_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            if_rvalid  <= 1'b0;
            dbg_rvalid <= 1'b0;
        end else begin
            if_rvalid  <= if_acc;
            dbg_rvalid <= dbg_rd;
        end
    end

    tcm_sram_1w2r #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_sram (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_en),
        .waddr   (wr_idx),
        .wbe     (wr_be),
        .wdata   (wr_data),
        .ra_en   (if_acc),
        .ra_zero (!if_map.ok),
        .ra_addr (if_map.idx[AW-1:0]),
        .ra_data (if_rdata),
        .rb_en   (dbg_rd),
        .rb_zero (!dbg_map.ok),
        .rb_addr (dbg_map.idx[AW-1:0]),
        .rb_data (dbg_rdata)
    );

endmodule

// File: tb/tb_tcm_autoload.sv
// Randomised self-checking bench for tcm_autoload against a word-level model
// of the loader, memory contents and read pipelines.
module tb_tcm_autoload;

    localparam int          DEPTH = 16;
    localparam int          LW    = 4;
    localparam logic [31:0] BASE  = 32'h0;
    localparam logic [31:0] SRC   = 32'h1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_ready, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        dbg_req, dbg_we, dbg_ready, dbg_rvalid;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic [3:0]  dbg_be;
    logic        ld_req_valid, ld_req_ready, ld_rsp_valid, ld_rsp_err;
    logic [31:0] ld_req_addr, ld_rsp_data;
    logic        reload, busy, load_err;
    logic [4:0]  load_cnt;

    always #5 clk = ~clk;

    tcm_autoload #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE),
        .LOAD_WORDS(LW), .LOAD_SRC(SRC)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_be(dbg_be),
        .dbg_wdata(dbg_wdata), .dbg_ready(dbg_ready), .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_addr(ld_req_addr),
        .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data), .ld_rsp_err(ld_rsp_err),
        .reload(reload), .busy(busy), .load_err(load_err), .load_cnt(load_cnt)
    );

    // model state
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    bit          m_busy, m_out, m_err;
    int          m_cnt, err_at, dly;
    logic [31:0] cur_addr;
    bit          e_if_v, e_dbg_v, e_if_k, e_dbg_k;
    logic [31:0] e_if_d, e_dbg_d;
    bit          chk_on;
    logic [31:0] req_log [$];
    int          n_checks, n_err;

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) >> 2) < DEPTH);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected read data for a read accepted this cycle, before this cycle's write.
    task automatic exp_read(input logic [31:0] a, input bit wr, output logic [31:0] d,
                            output bit k);
        if (!in_rng(a)) begin
            d = '0;
            k = 1'b1;
        end else begin
            d = m_mem[idx_of(a)];
            k = m_known[idx_of(a)];
`ifdef TCM_WR_BYPASS_EN
            if (wr && idx_of(dbg_addr) == idx_of(a)) begin
                d = merge(d, dbg_wdata, dbg_be);
                k = k || (dbg_be == 4'hF);
            end
`endif
        end
    endtask

    // One clock: drive bus, check outputs, advance model. Entered at edge+1.
    task automatic step();
        bit          busy0, hs, rsp, if_acc, dbg_rd, dbg_wr, if_k, dbg_k;
        logic [31:0] if_d, dbg_d;
        ld_req_ready = ($urandom_range(0, 2) != 0);
        if (rst) begin
            ld_rsp_valid = 1'b0;
        end else if (m_out && dly == 0) begin
            ld_rsp_valid = 1'b1;
            ld_rsp_data  = cur_addr ^ 32'hA5A5A5A5;
            ld_rsp_err   = (err_at == m_cnt + 1);
        end else if (m_out) begin
            dly--;
            ld_rsp_valid = 1'b0;
        end else begin
            ld_rsp_valid = ($urandom_range(0, 7) == 0);
            ld_rsp_data  = $urandom;
            ld_rsp_err   = $urandom_range(0, 1) == 1;
        end
        #1;
        if (chk_on) begin
            chk("busy", busy, m_busy);
            chk("if_ready", if_ready, !m_busy);
            chk("dbg_ready", dbg_ready, !m_busy);
            chk("ld_req_valid", ld_req_valid, m_busy && !m_out && !rst);
            if (m_busy && !m_out && !rst) chk("ld_req_addr", ld_req_addr, SRC + 4 * m_cnt);
            chk("load_cnt", load_cnt, m_cnt);
            chk("load_err", load_err, m_err);
            chk("if_rvalid", if_rvalid, e_if_v);
            if (e_if_v && e_if_k) chk("if_rdata", if_rdata, e_if_d);
            chk("dbg_rvalid", dbg_rvalid, e_dbg_v);
            if (e_dbg_v && e_dbg_k) chk("dbg_rdata", dbg_rdata, e_dbg_d);
        end
        busy0  = m_busy;
        hs     = m_busy && !m_out && !rst && ld_req_ready;
        rsp    = m_out && ld_rsp_valid && !rst;
        if (hs) req_log.push_back(ld_req_addr);
        if_acc = if_req && !m_busy;
        dbg_rd = dbg_req && !dbg_we && !m_busy;
        dbg_wr = dbg_req && dbg_we && !m_busy && in_rng(dbg_addr);
        exp_read(if_addr, dbg_wr, if_d, if_k);
        exp_read(dbg_addr, dbg_wr, dbg_d, dbg_k);
        @(posedge clk);
        #1;
        if (dbg_wr) begin
            m_mem[idx_of(dbg_addr)] = merge(m_mem[idx_of(dbg_addr)], dbg_wdata, dbg_be);
            if (dbg_be == 4'hF) m_known[idx_of(dbg_addr)] = 1'b1;
        end
        if (rst) begin
            m_cnt = 0; m_err = 0; m_busy = (LW > 0); m_out = 0;
            e_if_v = 0; e_dbg_v = 0; e_if_d = '0; e_dbg_d = '0; e_if_k = 1; e_dbg_k = 1;
        end else begin
            if (rsp) begin
                if (ld_rsp_err) begin
                    m_err  = 1;
                    m_busy = 0;
                end else begin
                    m_mem[m_cnt]   = ld_rsp_data;
                    m_known[m_cnt] = 1'b1;
                    m_cnt++;
                    if (m_cnt == LW) m_busy = 0;
                end
                m_out = 0;
            end
            if (hs) begin
                m_out    = 1;
                cur_addr = SRC + 4 * m_cnt;
                dly      = $urandom_range(0, 2);
            end
            if (reload && !busy0 && LW > 0) begin
                m_busy = 1; m_cnt = 0; m_err = 0;
            end
            e_if_v = if_acc;
            if (if_acc) begin e_if_d = if_d; e_if_k = if_k; end
            e_dbg_v = dbg_rd;
            if (dbg_rd) begin e_dbg_d = dbg_d; e_dbg_k = dbg_k; end
        end
        if_req  = 1'b0;
        dbg_req = 1'b0;
        reload  = 1'b0;
    endtask

    task automatic rand_inputs();
        if_req    = $urandom_range(0, 1) == 1;
        if_addr   = $urandom_range(0, 19) * 4 + $urandom_range(0, 3);
        dbg_req   = $urandom_range(0, 1) == 1;
        dbg_we    = $urandom_range(0, 1) == 1;
        dbg_addr  = $urandom_range(0, 19) * 4 + $urandom_range(0, 3);
        dbg_be    = 4'($urandom);
        dbg_wdata = $urandom;
        reload    = ($urandom_range(0, 9) == 0);
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (m_busy && n < max) begin
            rand_inputs();
            step();
            n++;
        end
        if (m_busy) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", max);
        end
    endtask

    task automatic dbg_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        dbg_req = 1; dbg_we = 1; dbg_addr = a; dbg_wdata = d; dbg_be = be;
        step();
    endtask

    initial begin
        rst = 1; if_req = 0; if_addr = 0; dbg_req = 0; dbg_we = 0; dbg_addr = 0;
        dbg_be = 0; dbg_wdata = 0; ld_req_ready = 0; ld_rsp_valid = 0; ld_rsp_data = 0;
        ld_rsp_err = 0; reload = 0;
        m_busy = (LW > 0); m_out = 0; m_err = 0; m_cnt = 0; err_at = 0; dly = 0;
        cur_addr = 0; e_if_v = 0; e_dbg_v = 0; e_if_d = 0; e_dbg_d = 0; e_if_k = 1; e_dbg_k = 1;
        n_checks = 0; n_err = 0; chk_on = 0;
        for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_known[i] = 1'b0; end

        repeat (2) @(posedge clk);
        #1;
        chk_on = 1;
        chk("rst_if_rvalid", if_rvalid, 0);
        chk("rst_dbg_rvalid", dbg_rvalid, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dbg_rdata", dbg_rdata, 0);
        chk("rst_ld_req_valid", ld_req_valid, 0);
        chk("rst_busy", busy, 1);
        chk("rst_load_cnt", load_cnt, 0);
        chk("rst_load_err", load_err, 0);
        step();
        rst = 0;
        req_log.delete();
        #1;
        chk("req_valid_after_rst", ld_req_valid, 1);
        chk("if_ready_busy", if_ready, 0);

        // auto-load with fetch/debug/reload noise while busy
        wait_idle(200);
        chk("req_count", req_log.size(), 4);
        for (int i = 0; i < 4 && i < req_log.size(); i++)
            chk("req_addr", req_log[i], SRC + 32'(4 * i));
        chk("load_cnt_done", load_cnt, 4);
        chk("busy_done", busy, 0);
        if_req = 1; if_addr = BASE + 8;
        step();
        chk("fetch_word2_valid", if_rvalid, 1);
        chk("fetch_word2", if_rdata, 32'hA5A5B5AD);

        // make every word known
        dbg_write(BASE, 32'h0, 4'hF);
        for (int i = 4; i < DEPTH; i++) dbg_write(BASE + 32'(4 * i), $urandom, 4'hF);
        dbg_write(BASE + 20, 32'h0, 4'hF);

        dbg_write(BASE, 32'h11223344, 4'b0101);
        dbg_req = 1; dbg_we = 0; dbg_addr = BASE;
        step();
        chk("dbg_be_read", dbg_rdata, 32'h00220044);

        // collision on word 5
        dbg_req = 1; dbg_we = 1; dbg_addr = BASE + 20; dbg_wdata = 32'hDEADBEEF; dbg_be = 4'hF;
        if_req = 1; if_addr = BASE + 20;
        step();
`ifdef TCM_WR_BYPASS_EN
        chk("collision_fetch", if_rdata, 32'hDEADBEEF);
`else
        chk("collision_fetch", if_rdata, 32'h00000000);
`endif

        // out of range
        if_req = 1; if_addr = BASE + DEPTH * 4;
        step();
        chk("oor_fetch_valid", if_rvalid, 1);
        chk("oor_fetch_data", if_rdata, 0);
        dbg_write(BASE + DEPTH * 4, 32'hCAFEF00D, 4'hF);
        for (int i = 0; i < DEPTH; i++) begin
            if_req = 1; if_addr = BASE + 32'(4 * i);
            step();
        end

        // random traffic, including loads started by random reloads
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            step();
        end
        wait_idle(200);

        // error abort on second response
        dbg_write(BASE + 4, 32'h12345678, 4'hF);
        err_at = 2;
        reload = 1;
        step();
        wait_idle(200);
        err_at = 0;
        chk("err_load_err", load_err, 1);
        chk("err_load_cnt", load_cnt, 1);
        chk("err_busy", busy, 0);
        if_req = 1; if_addr = BASE + 4;
        step();
        chk("err_word1_kept", if_rdata, 32'h12345678);

        // reset in the middle of a load
        reload = 1;
        step();
        for (int n = 0; n < 100 && m_cnt < 2; n++) step();
        chk("midload_cnt_reached", m_cnt >= 2, 1);
        rst = 1;
        step();
        rst = 0;
        req_log.delete();
        wait_idle(200);
        chk("restart_first_req", (req_log.size() > 0) ? req_log[0] : 32'hFFFFFFFF, SRC);
        chk("restart_load_cnt", load_cnt, 4);
        chk("restart_load_err", load_err, 0);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/tcm_autoload.md
# tcm_autoload

Parametrised tightly-coupled memory with a built-in boot loader, successor to the fixed 32-bit instruction TCM. Holds DEPTH words of DATA_W bits at BASE_ADDR. Serves a registered instruction-fetch read port and a debug read/write port with byte enables. After reset, or on request, it fills itself from the system bus through a one-outstanding request/response handshake, with error abort and a progress count.

## Interface
- DATA_W, 32: word width; multiple of 8.
- ADDR_W, 32: byte-address width.
- DEPTH, 8192: words; power of two.
- BASE_ADDR, 32'h0: byte address of word 0; DEPTH·DATA_W/8 aligned.
- LOAD_WORDS, DEPTH: words to auto-load, 0..DEPTH; 0 disables the loader.
- LOAD_SRC, BASE_ADDR: bus byte address of the first load word.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch byte address.
- if_ready  out  1  fetch accepted.
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  DATA_W  fetch data.
- dbg_req  in  1  debug request.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  ADDR_W  debug byte address.
- dbg_be  in  DATA_W/8  byte enables.
- dbg_wdata  in  DATA_W  write data.
- dbg_ready  out  1  debug accepted.
- dbg_rvalid  out  1  debug read data valid.
- dbg_rdata  out  DATA_W  debug read data.
- ld_req_valid  out  1  load request valid.
- ld_req_ready  in  1  bus accepts the request.
- ld_req_addr  out  ADDR_W  load source address.
- ld_rsp_valid  in  1  response valid.
- ld_rsp_data  in  DATA_W  response data.
- ld_rsp_err  in  1  response error, qualified by ld_rsp_valid.
- reload  in  1  pulse: restart the load.
- busy  out  1  load in progress.
- load_err  out  1  sticky error flag.
- load_cnt  out  clog2(DEPTH+1)  words written by the current or last load.

## Operation
- Word index: (addr − BASE_ADDR) >> log2(DATA_W/8).
- An address is in range when the index is < DEPTH and addr ≥ BASE_ADDR.
- Out-of-range access:
  - read returns 0;
  - write is dropped;
  - the access still handshakes.
- Loader FSM:
  - IDLE: busy=0. On reload=1 and LOAD_WORDS>0, go to REQ; load_cnt ← 0; load_err ← 0.
  - REQ: ld_req_valid=1 and ld_req_addr=LOAD_SRC+load_cnt·DATA_W/8. On ld_req_ready, go to WAIT.
  - WAIT: on ld_rsp_valid with err=0, write ld_rsp_data to word load_cnt with all bytes enabled, then load_cnt+1.
    - If the new load_cnt equals LOAD_WORDS, go to IDLE.
    - Otherwise go to REQ.
  - WAIT, error: on ld_rsp_valid with err=1, set load_err, write nothing, go to IDLE.
- Reset state:
  - LOAD_WORDS>0: REQ, so the load starts immediately.
  - LOAD_WORDS=0: IDLE.
- Port availability: busy = state≠IDLE. While busy, if_ready=0 and dbg_ready=0.
- Write port, shared: loader has priority; the debug port can only write while idle.
- Reads: two independent read ports, registered.
- reload while busy: ignored.
- rst mid-load: the load restarts from word 0. Memory contents are not cleared.
- Response with no request outstanding (IDLE/REQ): ignored.

## Timing
- Reset values: if_rvalid=0, dbg_rvalid=0, if_rdata=0, dbg_rdata=0, ld_req_valid=0, load_err=0, load_cnt=0.
- busy reset value: 1 if LOAD_WORDS>0, else 0.
- ld_req_valid rises the first cycle after rst deasserts.
- Read latency is 1 cycle: request accepted in cycle N → rvalid=1 and data in N+1. rvalid is 1 cycle wide.
- No back-pressure on read data; if_ready/dbg_ready are combinational from busy.
- Debug write completes in the accept cycle; dbg_rvalid stays 0 for writes.
- Minimum 2 cycles per load word: REQ, then a WAIT response in the following cycle.
- ld_req_valid/addr are held stable until ld_req_ready.
- busy falls the cycle after the final response.

## Configuration
- TCM_WR_BYPASS_EN defined: a read accepted in the same cycle as a debug write to the same word returns the byte-merged new data.
- TCM_WR_BYPASS_EN undefined: that read returns the old contents (read-before-write).

## Structure
- Package tcm_pkg holds:
  - loader state enum: IDLE, REQ, WAIT;
  - clog2 helper;
  - function for address-to-index conversion with range check.
- Sub-module tcm_sram_1w2r: DEPTH×DATA_W array with byte-enable write port and two registered read ports. Bypass logic lives in this sub-module.
- The top level holds the FSM, arbitration and range checks.

## Test plan
- Auto-load: DEPTH=16, LOAD_WORDS=4, LOAD_SRC=0x1000, bus returns addr^0xA5A5A5A5.
  - Requests go to 0x1000..0x100C.
  - busy falls after the 4th response; load_cnt=4.
  - Fetch of BASE+8 returns 0xA5A5B5AD.
- Error abort: response 2 has err=1.
  - load_err=1, load_cnt=1, busy=0.
  - Word 1 keeps its prior value.
- Debug write: dbg_be=4'b0101, wdata 0x11223344 on word 0x00000000, then debug read → 0x00220044.
- Collision: same-cycle debug write of 0xDEADBEEF and fetch of the same word.
  - With the macro: fetch returns 0xDEADBEEF.
  - Without: fetch returns 0x00000000.
- Blocking: fetch and reload during busy.
  - if_ready=0; the reload is ignored and load_cnt is not reset.
  - rst asserted mid-load → the first request is LOAD_SRC again.
- Out of range: read at BASE+DEPTH·4 → rvalid=1 with rdata=0; a write there leaves all words unchanged.
